// File: rtl/alu_seq_pkg.sv
// Shared encodings for the ALU sequencer: instruction classes, FSM states,
// ALU modes, flag bit positions and the instruction word layout.
package alu_seq_pkg;

  localparam int unsigned INSN_W = 16;
  localparam int unsigned CLS_W  = 4;
  localparam int unsigned MODE_W = 4;
  localparam int unsigned ARG_W  = 8;
  localparam int unsigned FLAG_W = 4;

  localparam logic [CLS_W-1:0] CLS_NOP     = 4'd0;
  localparam logic [CLS_W-1:0] CLS_ALU_MEM = 4'd1;
  localparam logic [CLS_W-1:0] CLS_ALU_IMM = 4'd2;
  localparam logic [CLS_W-1:0] CLS_STORE   = 4'd3;
  localparam logic [CLS_W-1:0] CLS_JMP     = 4'd4;
  localparam logic [CLS_W-1:0] CLS_JZ      = 4'd5;
  localparam logic [CLS_W-1:0] CLS_JC      = 4'd6;
  localparam logic [CLS_W-1:0] CLS_HALT    = 4'd7;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_MEM    = 3'd2,
    S_EXEC   = 3'd3,
    S_HALT   = 3'd4
  } state_e;

  localparam logic [MODE_W-1:0] MODE_ADD   = 4'b0000;
  localparam logic [MODE_W-1:0] MODE_SUB   = 4'b0001;
  localparam logic [MODE_W-1:0] MODE_PASS1 = 4'b0010;
  localparam logic [MODE_W-1:0] MODE_PASS2 = 4'b0011;
  localparam logic [MODE_W-1:0] MODE_AND   = 4'b0100;
  localparam logic [MODE_W-1:0] MODE_OR    = 4'b0101;
  localparam logic [MODE_W-1:0] MODE_XOR   = 4'b0110;
  localparam logic [MODE_W-1:0] MODE_NOT   = 4'b0111;
  localparam logic [MODE_W-1:0] MODE_SHL   = 4'b1000;
  localparam logic [MODE_W-1:0] MODE_SHR   = 4'b1001;
  localparam logic [MODE_W-1:0] MODE_ROL   = 4'b1010;
  localparam logic [MODE_W-1:0] MODE_ROR   = 4'b1011;
  localparam logic [MODE_W-1:0] MODE_INC   = 4'b1100;
  localparam logic [MODE_W-1:0] MODE_DEC   = 4'b1101;
  localparam logic [MODE_W-1:0] MODE_XNOR  = 4'b1110;
  localparam logic [MODE_W-1:0] MODE_NEG   = 4'b1111;

  localparam int unsigned FLAG_Z = 3;
  localparam int unsigned FLAG_C = 2;
  localparam int unsigned FLAG_S = 1;
  localparam int unsigned FLAG_O = 0;

  typedef struct packed {
    logic [CLS_W-1:0]  cls;
    logic [MODE_W-1:0] mode;
    logic [ARG_W-1:0]  arg;
  } insn_t;

  function automatic logic is_alu_cls(input logic [CLS_W-1:0] cls);
    return (cls == CLS_ALU_MEM) || (cls == CLS_ALU_IMM);
  endfunction

endpackage

// File: rtl/alu_seq_fsm.sv
// Sequencer state machine: state register plus next-state and strobe decode.
module alu_seq_fsm
  import alu_seq_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [CLS_W-1:0] pm_cls,
  input  logic [CLS_W-1:0] ir_cls,
  output state_e           state_q,
  output logic             dm_re_c,
  output logic             dm_we_c,
  output logic             alu_en_c,
  output logic             halted_c
);

  state_e state_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_FETCH;
    else     state_q <= state_d;
  end

  // Memory-operand reads are launched from the word arriving in DECODE.
  always_comb begin
    state_d  = state_q;
    dm_re_c  = 1'b0;
    dm_we_c  = 1'b0;
    alu_en_c = 1'b0;
    halted_c = 1'b0;
    case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        if (pm_cls == CLS_ALU_MEM) begin
          dm_re_c = 1'b1;
          state_d = S_MEM;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_MEM:    state_d = S_EXEC;
      S_EXEC: begin
        alu_en_c = is_alu_cls(ir_cls);
        dm_we_c  = (ir_cls == CLS_STORE);
        state_d  = (ir_cls == CLS_HALT) ? S_HALT : S_FETCH;
      end
      S_HALT:   halted_c = 1'b1;
      default:  state_d = S_FETCH;
    endcase
  end

endmodule

// File: rtl/alu_sequencer.sv
// Multi-cycle control unit: fetches, decodes and sequences the shared ALU;
// owns PC, IR, accumulator, flags and the data-memory strobes.
module alu_sequencer
  import alu_seq_pkg::*;
#(
  parameter int unsigned PC_W   = 8,
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  output logic [PC_W-1:0]   pm_addr,
  input  logic [15:0]       pm_data,
  output logic [7:0]        dm_addr,
  output logic              dm_re,
  input  logic [DATA_W-1:0] dm_rdata,
  output logic              dm_we,
  output logic [DATA_W-1:0] dm_wdata,
  output logic [DATA_W-1:0] alu_op1,
  output logic [DATA_W-1:0] alu_op2,
  output logic [3:0]        alu_mode,
  output logic              alu_en,
  input  logic [DATA_W-1:0] alu_out,
  input  logic [3:0]        alu_flags,
  output logic [DATA_W-1:0] acc,
  output logic [3:0]        flags,
  output logic              halted
);

  insn_t             pm_insn;
  insn_t             ir_q, ir_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic [DATA_W-1:0] acc_q, acc_d;
  logic [DATA_W-1:0] op1_q, op1_d;
  logic [FLAG_W-1:0] flags_q, flags_d;
  state_e            state;
  logic              dm_re_c, dm_we_c, alu_en_c, halted_c;

  assign pm_insn = insn_t'(pm_data);

  alu_seq_fsm u_fsm (
    .clk      (clk),
    .rst      (rst),
    .pm_cls   (pm_insn.cls),
    .ir_cls   (ir_q.cls),
    .state_q  (state),
    .dm_re_c  (dm_re_c),
    .dm_we_c  (dm_we_c),
    .alu_en_c (alu_en_c),
    .halted_c (halted_c)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q    <= '0;
      ir_q    <= '0;
      acc_q   <= '0;
      op1_q   <= '0;
      flags_q <= '0;
    end else begin
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      acc_q   <= acc_d;
      op1_q   <= op1_d;
      flags_q <= flags_d;
    end
  end

  // op1 holds the immediate from DECODE, overwritten by memory data in MEM.
  always_comb begin
    pc_d    = pc_q;
    ir_d    = ir_q;
    acc_d   = acc_q;
    op1_d   = op1_q;
    flags_d = flags_q;
    case (state)
      S_DECODE: begin
        ir_d  = pm_insn;
        pc_d  = pc_q + PC_W'(1);
        op1_d = DATA_W'(pm_insn.arg);
      end
      S_MEM: op1_d = dm_rdata;
      S_EXEC: begin
        if (alu_en_c) begin
          acc_d   = alu_out;
          flags_d = alu_flags;
        end
        case (ir_q.cls)
          CLS_JMP: pc_d = PC_W'(ir_q.arg);
          CLS_JZ:  if (flags_q[FLAG_Z]) pc_d = PC_W'(ir_q.arg);
          CLS_JC:  if (flags_q[FLAG_C]) pc_d = PC_W'(ir_q.arg);
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  assign pm_addr  = pc_q;
  assign dm_addr  = (state == S_DECODE) ? pm_insn.arg : ir_q.arg;
  assign dm_re    = dm_re_c;
  assign dm_we    = dm_we_c;
  assign dm_wdata = acc_q;
  assign alu_op1  = op1_q;
  assign alu_op2  = acc_q;
  assign alu_mode = ir_q.mode;
  assign alu_en   = alu_en_c;
  assign acc      = acc_q;
  assign flags    = flags_q;
  assign halted   = halted_c;

endmodule
